// File: rtl/vpg_pkg.sv
// Shared types and constants for the video pattern generator / checker pair:
// band colours, checker FSM states and counter widths.
package vpg_pkg;

  localparam int ERR_CNT_W = 24;
  localparam int POS_W     = 12;

  localparam logic [23:0] BAND_RED    = 24'hFF0000;
  localparam logic [23:0] BAND_GREEN  = 24'h00FF00;
  localparam logic [23:0] BAND_BLUE   = 24'h0000FF;
  localparam logic [23:0] BAND_YELLOW = 24'hFFFF00;
  localparam logic [23:0] BAND_BLACK  = 24'h000000;

  typedef enum logic {
    SEEK,
    CHECK
  } chk_state_e;

  // Position counters stick at all-ones instead of wrapping.
  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rgb_band_expect.sv
// Expected pattern colour for a given active line: four horizontal bands,
// black below the last band or past the active height.
module rgb_band_expect
  import vpg_pkg::*;
#(
  parameter int BAND_LINES = 270,
  parameter int V_ACTIVE   = 1080
) (
  input  logic [POS_W-1:0] y_i,
  output logic [23:0]      rgb_o
);

  localparam logic [POS_W-1:0] B1 = POS_W'(BAND_LINES);
  localparam logic [POS_W-1:0] B2 = POS_W'(2 * BAND_LINES);
  localparam logic [POS_W-1:0] B3 = POS_W'(3 * BAND_LINES);
  localparam logic [POS_W-1:0] B4 = POS_W'(4 * BAND_LINES);
  localparam logic [POS_W-1:0] VA = POS_W'(V_ACTIVE);

  // Threshold compares stand in for y / BAND_LINES, so no divider is built.
  always_comb begin
    // NOTE: a default assignment first means no path through this block can leave a latch.
    rgb_o = BAND_BLACK;
    if (y_i < VA) begin
      if (y_i < B1)      rgb_o = BAND_RED;
      else if (y_i < B2) rgb_o = BAND_GREEN;
      else if (y_i < B3) rgb_o = BAND_BLUE;
      else if (y_i < B4) rgb_o = BAND_YELLOW;
    end
  end

endmodule

// File: rtl/rgb_band_checker.sv
// Receive-side checker for the four-band colour-bar pattern; publishes per-frame results.
// Define ERR_CAPTURE_EN to add first_err_x/first_err_y/first_err_rgb capture ports.
module rgb_band_checker
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int BAND_LINES = 270
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vid_de,
  input  logic                 vid_vs,
  input  logic [7:0]           vid_r,
  input  logic [7:0]           vid_g,
  input  logic [7:0]           vid_b,
  output logic                 frame_done,
  output logic                 frame_pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 geom_err,
  output logic                 locked
`ifdef ERR_CAPTURE_EN
  ,
  output logic [POS_W-1:0]     first_err_x,
  output logic [POS_W-1:0]     first_err_y,
  output logic [23:0]          first_err_rgb
`endif
);

  localparam logic [POS_W-1:0] H_LEN = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_LEN = POS_W'(V_ACTIVE);

  // s1 input register
  logic        s1_de_q, s1_vs_q;
  logic [23:0] s1_rgb_q;

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
    if (reset) begin
      s1_de_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_rgb_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      s1_de_q  <= vid_de;
      s1_vs_q  <= vid_vs;
      s1_rgb_q <= {vid_r, vid_g, vid_b};
    end
  end

  // Position tracking and compare, all driven from s1
  logic             de_prev_q, vs_prev_q;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d, y_sel, x_sel, y_close;
  logic             vs_rise, de_fall, line_end, line_bad, frame_bad;
  logic [23:0]      exp_rgb;

  always_comb begin
    vs_rise  = s1_vs_q & ~vs_prev_q;
    de_fall  = de_prev_q & ~s1_de_q;
    line_end = de_fall | (vs_rise & de_prev_q);
    // A line still in DE when vsync rises is cut short and always flags geometry.
    line_bad = line_end & (s1_de_q | (x_q != H_LEN));
    y_close  = de_prev_q ? pos_inc(y_q) : y_q;
    frame_bad = vs_rise & (y_close != V_LEN);
    y_sel    = vs_rise ? '0 : y_q;
    x_sel    = vs_rise ? '0 : x_q;

    x_d = x_q;
    y_d = y_q;
    if (vs_rise) begin
      x_d = s1_de_q ? POS_W'(1) : '0;
      y_d = '0;
    end else if (s1_de_q) begin
      x_d = pos_inc(x_q);
    end else if (de_fall) begin
      x_d = '0;
      y_d = pos_inc(y_q);
    end
  end

  rgb_band_expect #(
    .BAND_LINES(BAND_LINES),
    .V_ACTIVE  (V_ACTIVE)
  ) u_expect (
    .y_i  (y_sel),
    .rgb_o(exp_rgb)
  );

  logic cmp_err_q, cmp_close_q, cmp_line_bad_q, cmp_close_geom_q;
`ifdef ERR_CAPTURE_EN
  logic [POS_W-1:0] cmp_x_q, cmp_y_q;
  logic [23:0]      cmp_rgb_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      de_prev_q        <= 1'b0;
      vs_prev_q        <= 1'b0;
      x_q              <= '0;
      y_q              <= '0;
      cmp_err_q        <= 1'b0;
      cmp_close_q      <= 1'b0;
      cmp_line_bad_q   <= 1'b0;
      cmp_close_geom_q <= 1'b0;
`ifdef ERR_CAPTURE_EN
      cmp_x_q          <= '0;
      cmp_y_q          <= '0;
      cmp_rgb_q        <= '0;
`endif
    end else begin
      de_prev_q        <= s1_de_q;
      vs_prev_q        <= s1_vs_q;
      x_q              <= x_d;
      y_q              <= y_d;
      cmp_err_q        <= s1_de_q & (s1_rgb_q != exp_rgb);
      cmp_close_q      <= vs_rise;
      cmp_line_bad_q   <= line_bad & ~vs_rise;
      cmp_close_geom_q <= (line_bad & vs_rise) | frame_bad;
`ifdef ERR_CAPTURE_EN
      cmp_x_q          <= x_sel;
      cmp_y_q          <= y_sel;
      cmp_rgb_q        <= s1_rgb_q;
`endif
    end
  end

  // Running frame accumulators; a close snapshots them and restarts with the
  // pixel that arrived alongside vsync, which belongs to the new frame.
  logic [ERR_CNT_W-1:0] err_run_q, err_inc_d, res_cnt_q;
  logic                 geom_run_q, res_geom_q, res_valid_q;
`ifdef ERR_CAPTURE_EN
  logic                 ferr_valid_q;
  logic [POS_W-1:0]     ferr_x_q, ferr_y_q, res_fx_q, res_fy_q;
  logic [23:0]          ferr_rgb_q, res_frgb_q;
`endif

  assign err_inc_d = (&err_run_q) ? err_run_q : err_run_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_run_q    <= '0;
      geom_run_q   <= 1'b0;
      res_cnt_q    <= '0;
      res_geom_q   <= 1'b0;
      res_valid_q  <= 1'b0;
`ifdef ERR_CAPTURE_EN
      ferr_valid_q <= 1'b0;
      ferr_x_q     <= '0;
      ferr_y_q     <= '0;
      ferr_rgb_q   <= '0;
      res_fx_q     <= '0;
      res_fy_q     <= '0;
      res_frgb_q   <= '0;
`endif
    end else begin
      res_valid_q <= cmp_close_q;
      if (cmp_close_q) begin
        res_cnt_q  <= err_run_q;
        res_geom_q <= geom_run_q | cmp_close_geom_q;
        err_run_q  <= ERR_CNT_W'(cmp_err_q);
        geom_run_q <= 1'b0;
`ifdef ERR_CAPTURE_EN
        res_fx_q     <= ferr_x_q;
        res_fy_q     <= ferr_y_q;
        res_frgb_q   <= ferr_rgb_q;
        ferr_valid_q <= cmp_err_q;
        ferr_x_q     <= cmp_err_q ? cmp_x_q : '0;
        ferr_y_q     <= cmp_err_q ? cmp_y_q : '0;
        ferr_rgb_q   <= cmp_err_q ? cmp_rgb_q : '0;
`endif
      end else begin
        if (cmp_err_q)      err_run_q  <= err_inc_d;
        if (cmp_line_bad_q) geom_run_q <= 1'b1;
`ifdef ERR_CAPTURE_EN
        if (cmp_err_q && !ferr_valid_q) begin
          ferr_valid_q <= 1'b1;
          ferr_x_q     <= cmp_x_q;
          ferr_y_q     <= cmp_y_q;
          ferr_rgb_q   <= cmp_rgb_q;
        end
`endif
      end
    end
  end

  // Publish FSM; the first close after reset only arms checking.
  chk_state_e           state_q;
  logic                 done_q, pass_q, geom_q, locked_q;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic                 res_pass;
`ifdef ERR_CAPTURE_EN
  logic [POS_W-1:0]     fx_q, fy_q;
  logic [23:0]          frgb_q;
`endif

  assign res_pass = (res_cnt_q == '0) && !res_geom_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEEK;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      cnt_q    <= '0;
      geom_q   <= 1'b0;
      locked_q <= 1'b0;
`ifdef ERR_CAPTURE_EN
      fx_q     <= '0;
      fy_q     <= '0;
      frgb_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SEEK: if (res_valid_q) state_q <= CHECK;
        CHECK: begin
          if (res_valid_q) begin
            done_q   <= 1'b1;
            cnt_q    <= res_cnt_q;
            geom_q   <= res_geom_q;
            pass_q   <= res_pass;
            locked_q <= res_pass;
`ifdef ERR_CAPTURE_EN
            fx_q     <= res_fx_q;
            fy_q     <= res_fy_q;
            frgb_q   <= res_frgb_q;
`endif
          end
        end
        default: state_q <= SEEK;
      endcase
    end
  end

  assign frame_done = done_q;
  assign frame_pass = pass_q;
  assign err_count  = cnt_q;
  assign geom_err   = geom_q;
  assign locked     = locked_q;
`ifdef ERR_CAPTURE_EN
  assign first_err_x   = fx_q;
  assign first_err_y   = fy_q;
  assign first_err_rgb = frgb_q;
`endif

endmodule

// File: tb/tb_rgb_band_checker.sv
// Scoreboard bench for rgb_band_checker on an 8x8 frame with 2-line bands.
// Define ERR_CAPTURE_EN to also check the first-error capture ports.
module tb_rgb_band_checker;

  localparam int          H  = 8;
  localparam int          V  = 8;
  localparam int          BL = 2;
  localparam logic [23:0] SAT_PRESET = 24'hFFFFF0;

  logic        clk = 1'b0;
  logic        reset, vid_de, vid_vs;
  logic [7:0]  vid_r, vid_g, vid_b;
  logic        frame_done, frame_pass, geom_err, locked;
  logic [23:0] err_count;
`ifdef ERR_CAPTURE_EN
  logic [11:0] first_err_x, first_err_y;
  logic [23:0] first_err_rgb;
`endif

  rgb_band_checker #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .BAND_LINES(BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vid_de    (vid_de),
    .vid_vs    (vid_vs),
    .vid_r     (vid_r),
    .vid_g     (vid_g),
    .vid_b     (vid_b),
    .frame_done(frame_done),
    .frame_pass(frame_pass),
    .err_count (err_count),
    .geom_err  (geom_err),
    .locked    (locked)
`ifdef ERR_CAPTURE_EN
    ,
    .first_err_x  (first_err_x),
    .first_err_y  (first_err_y),
    .first_err_rgb(first_err_rgb)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] err;
    bit          geom;
    bit          pass;
    bit          lock;
    logic [11:0] fx;
    logic [11:0] fy;
    logic [23:0] frgb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state for the frame being driven
  logic [23:0] m_err;
  bit          m_geom, m_have, m_lock, armed;
  logic [11:0] m_fx, m_fy;
  logic [23:0] m_frgb;
  int          m_lines;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] band(input int y);
    if (y >= V || y >= 4 * BL) return 24'h000000;
    case (y / BL)
      0:       return 24'hFF0000;
      1:       return 24'h00FF00;
      2:       return 24'h0000FF;
      default: return 24'hFFFF00;
    endcase
  endfunction

  task automatic model_clear();
    m_err   = '0;
    m_geom  = 1'b0;
    m_have  = 1'b0;
    m_fx    = '0;
    m_fy    = '0;
    m_frgb  = '0;
    m_lines = 0;
  endtask

  always @(negedge clk) begin
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'd0, frame_done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_latency", cyc, mon_e.due);
        check("err_count", {8'd0, err_count}, {8'd0, mon_e.err});
        check("geom_err", {31'd0, geom_err}, {31'd0, mon_e.geom});
        check("frame_pass", {31'd0, frame_pass}, {31'd0, mon_e.pass});
        check("locked", {31'd0, locked}, {31'd0, mon_e.lock});
`ifdef ERR_CAPTURE_EN
        check("first_err_x", {20'd0, first_err_x}, {20'd0, mon_e.fx});
        check("first_err_y", {20'd0, first_err_y}, {20'd0, mon_e.fy});
        check("first_err_rgb", {8'd0, first_err_rgb}, {8'd0, mon_e.frgb});
`endif
      end
    end
  end

  task automatic do_vsync();
    exp_t e;
    @(negedge clk);
    vid_vs = 1'b1;
    vid_de = 1'b0;
    if (m_lines != V) m_geom = 1'b1;
    if (armed) begin
      e.due  = cyc + 4;
      e.err  = m_err;
      e.geom = m_geom;
      e.pass = (m_err == 0) && !m_geom;
      m_lock = e.pass;
      e.lock = m_lock;
      e.fx   = m_fx;
      e.fy   = m_fy;
      e.frgb = m_frgb;
      exp_q.push_back(e);
    end
    armed = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    vid_vs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset  = 1'b1;
    vid_de = 1'b0;
    @(negedge clk);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_pass", {31'd0, frame_pass}, 32'd0);
    check("rst_err_count", {8'd0, err_count}, 32'd0);
    check("rst_geom_err", {31'd0, geom_err}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    reset  = 1'b0;
    armed  = 1'b0;
    m_lock = 1'b0;
    model_clear();
  endtask

  task automatic send_frame(input int n_lines, input int short_line, input int bad_line,
                            input int bad_x, input logic [23:0] bad_rgb, input bit red_tail,
                            input bit all_wrong, input bit sat_force, input int reset_line);
    logic [23:0] px;
    int          len;
    do_vsync();
    if (sat_force) begin
      force dut.err_run_q = SAT_PRESET;
      #1;
      release dut.err_run_q;
      m_err = SAT_PRESET;
    end
    for (int y = 0; y < n_lines; y++) begin
      if (y == reset_line) pulse_reset();
      len = (y == short_line) ? H - 1 : H;
      for (int x = 0; x < len; x++) begin
        px = band(y);
        if (y >= V && red_tail) px = 24'hFF0000;
        if (all_wrong) px = px ^ 24'h010101;
        if (y == bad_line && x == bad_x) px = bad_rgb;
        @(negedge clk);
        vid_de = 1'b1;
        {vid_r, vid_g, vid_b} = px;
        if (px != band(y)) begin
          if (m_err != 24'hFFFFFF) m_err = m_err + 1'b1;
          if (!m_have) begin
            m_have = 1'b1;
            m_fx   = 12'(x);
            m_fy   = 12'(y);
            m_frgb = px;
          end
        end
      end
      @(negedge clk);
      vid_de = 1'b0;
      {vid_r, vid_g, vid_b} = 24'h0;
      if (len != H) m_geom = 1'b1;
      repeat (2) @(negedge clk);
    end
    m_lines = n_lines;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    vid_de = 1'b0;
    vid_vs = 1'b0;
    {vid_r, vid_g, vid_b} = 24'h0;
    armed  = 1'b0;
    m_lock = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("init_frame_done", {31'd0, frame_done}, 32'd0);
    check("init_frame_pass", {31'd0, frame_pass}, 32'd0);
    check("init_err_count", {8'd0, err_count}, 32'd0);
    check("init_geom_err", {31'd0, geom_err}, 32'd0);
    check("init_locked", {31'd0, locked}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(V, -1, -1, -1, 24'h0, 1'b0, 1'b0, 1'b0, -1);          // first, unpublished
    send_frame(V, -1, -1, -1, 24'h0, 1'b0, 1'b0, 1'b0, -1);          // clean
    send_frame(V, -1, 3, 5, 24'h00FF01, 1'b0, 1'b0, 1'b0, -1);       // single bad pixel
    send_frame(V, 6, -1, -1, 24'h0, 1'b0, 1'b0, 1'b0, -1);           // short line
    send_frame(V + 1, -1, -1, -1, 24'h0, 1'b0, 1'b0, 1'b0, -1);      // extra black line
    send_frame(V + 1, -1, -1, -1, 24'h0, 1'b1, 1'b0, 1'b0, -1);      // extra red line
    send_frame(V, -1, -1, -1, 24'h0, 1'b0, 1'b0, 1'b0, -1);          // clean, relock
    send_frame(V, -1, -1, -1, 24'h0, 1'b0, 1'b1, 1'b1, -1);          // saturation
    send_frame(V, -1, -1, -1, 24'h0, 1'b0, 1'b0, 1'b0, 4);           // reset mid-frame
    send_frame(V, -1, -1, -1, 24'h0, 1'b0, 1'b0, 1'b0, -1);          // unpublished after reset
    send_frame(V, -1, -1, -1, 24'h0, 1'b0, 1'b0, 1'b0, -1);          // publishes normally
    do_vsync();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("results_drained", exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
